// File: rtl/vga_timing_pkg.sv
// Mode constants for the VGA raster generator plus the line/frame total helper.
// Pure constants and functions; no logic, no latency.
package vga_timing_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_HS_POL   = 1'b0;
  localparam bit VGA640_VS_POL   = 1'b0;
  localparam int VGA640_CNT_W    = 10;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam bit SVGA800_HS_POL   = 1'b1;
  localparam bit SVGA800_VS_POL   = 1'b1;
  localparam int SVGA800_CNT_W    = 11;

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the raster generator: pixel enable in, sync/enable/coordinates/strobes out.
// Master is the timing generator, slave is the pixel pipeline that supplies ce.
interface vga_timing_if #(
  parameter int CNT_W = 10
) ();

  logic             ce;
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  ce,
    output hsync, vsync, de, x, y, line_start, frame_start
  );

  modport slave (
    output ce,
    input  hsync, vsync, de, x, y, line_start, frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with combinational region decode (active, sync level, wrap).
// Advances only when en is high; wrap pulses on the enabled cycle that rolls the count to 0.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int W      = 10
) (
  input  logic         clk25,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam int TOTAL = total(ACTIVE, FP, SYNC, BP);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_timing
    $error("vga_axis_counter: every timing parameter must be at least 1");
  end

  if (W < 1 || W > 30 || TOTAL > (1 << W)) begin : g_bad_width
    $error("vga_axis_counter: total count does not fit in W bits");
  end

  localparam logic [W-1:0] C_ACT_END    = W'(ACTIVE);
  localparam logic [W-1:0] C_SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] C_SYNC_END   = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] C_LAST       = W'(TOTAL - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;
  logic         w_in_sync;

  always_ff @(posedge clk25) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + W'(1);
    end
  end

  assign w_last    = (r_cnt == C_LAST);
  assign w_in_sync = (r_cnt >= C_SYNC_START) && (r_cnt <= C_SYNC_END);

  assign cnt    = r_cnt;
  assign wrap   = en & w_last;
  assign active = (r_cnt < C_ACT_END);
  assign sync   = w_in_sync ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator; outputs lag the counters by one clk25, all aligned.
// No backpressure: ce gates advance, level outputs hold and strobes drop on ce=0 cycles.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit HS_POL   = VGA640_HS_POL,
  parameter bit VS_POL   = VGA640_VS_POL,
  parameter int CNT_W    = VGA640_CNT_W
) (
  input  logic        clk25,
  input  logic        rst,
  vga_timing_if.master vga
);

  logic             w_ce;
  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_h_wrap;
  logic             w_h_act;
  logic             w_h_sync;
  logic             w_v_en;
  logic             w_unused_v_wrap;
  logic             w_v_act;
  logic             w_v_sync;

  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_line_start;
  logic             r_frame_start;

  assign w_ce   = vga.ce;
  assign w_v_en = w_ce & w_h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .W      (CNT_W)
  ) u_h_axis (
    .clk25  (clk25),
    .rst    (rst),
    .en     (w_ce),
    .cnt    (w_h_cnt),
    .wrap   (w_h_wrap),
    .active (w_h_act),
    .sync   (w_h_sync)
  );

  // Vertical axis steps once per line, on the pixel that ends the line
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .W      (CNT_W)
  ) u_v_axis (
    .clk25  (clk25),
    .rst    (rst),
    .en     (w_v_en),
    .cnt    (w_v_cnt),
    .wrap   (w_unused_v_wrap),
    .active (w_v_act),
    .sync   (w_v_sync)
  );

  always_ff @(posedge clk25) begin
    if (rst) begin
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_ce) begin
      r_hsync       <= w_h_sync;
      r_vsync       <= w_v_sync;
      r_de          <= w_h_act & w_v_act;
      r_x           <= w_h_cnt;
      r_y           <= w_v_cnt;
      r_line_start  <= (w_h_cnt == '0);
      r_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.de          = r_de;
  assign vga.x           = r_x;
  assign vga.y           = r_y;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;

endmodule
